// File: rtl/mm_fifo_pkg.sv
// Shared register map constants for the multi-channel memory-mapped FIFO.
package mm_fifo_pkg;

    // Per-channel register offsets (mem_addr[3:0])
    localparam logic [3:0] OFF_DATA    = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_CONTROL = 4'h8;
    localparam logic [3:0] OFF_THRESH  = 4'hC;

    // STATUS bit positions
    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_AEMPTY    = 2;
    localparam int unsigned ST_AFULL     = 3;
    localparam int unsigned ST_OVF       = 4;
    localparam int unsigned ST_UNF       = 5;
    localparam int unsigned ST_COUNT_LSB = 8;

    // CONTROL bit positions
    localparam int unsigned CTRL_FLUSH      = 0;
    localparam int unsigned CTRL_IRQ_EN_LSB = 8;
    localparam int unsigned CTRL_IRQ_EN_W   = 4;

    // THRESH field positions
    localparam int unsigned THR_AE_LSB = 0;
    localparam int unsigned THR_AF_LSB = 16;

endpackage

// File: rtl/mm_fifo_multichannel_if.sv
// Register bus plus per-channel streaming push/pop signals.
interface mm_fifo_multichannel_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4
);
    logic                         mem_valid;
    logic                         mem_write;
    logic [7:0]                   mem_addr;
    logic [DATA_WIDTH-1:0]        mem_wdata;
    logic                         mem_ready;
    logic [DATA_WIDTH-1:0]        mem_rdata;
    logic [NUM_CH-1:0]            ext_wr_en;
    logic [NUM_CH*DATA_WIDTH-1:0] ext_wr_data;
    logic [NUM_CH-1:0]            ext_wr_ready;
    logic [NUM_CH-1:0]            ext_rd_en;
    logic [NUM_CH*DATA_WIDTH-1:0] ext_rd_data;
    logic [NUM_CH-1:0]            ext_rd_valid;

    modport master (
        output mem_valid, mem_write, mem_addr, mem_wdata,
        output ext_wr_en, ext_wr_data, ext_rd_en,
        input  mem_ready, mem_rdata, ext_wr_ready, ext_rd_data, ext_rd_valid
    );

    modport slave (
        input  mem_valid, mem_write, mem_addr, mem_wdata,
        input  ext_wr_en, ext_wr_data, ext_rd_en,
        output mem_ready, mem_rdata, ext_wr_ready, ext_rd_data, ext_rd_valid
    );
endinterface

// File: rtl/mm_fifo_channel.sv
// One FIFO channel: storage, pointers, thresholds, sticky flags, stream handshake.
// Optional interrupt enables built when MMFIFO_IRQ_EN is defined.
module mm_fifo_channel
    import mm_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AE_RESET   = 2,
    parameter int unsigned AF_RESET   = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_push,
    input  logic                  bus_pop,
    input  logic                  status_we,
    input  logic                  ctrl_we,
    input  logic                  thr_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ext_wr_en,
    input  logic [DATA_WIDTH-1:0] ext_wr_data,
    input  logic                  ext_rd_en,
    output logic                  ext_wr_ready_c,
    output logic                  ext_rd_valid_c,
    output logic [DATA_WIDTH-1:0] head_c,
    output logic [DATA_WIDTH-1:0] status_c,
    output logic [DATA_WIDTH-1:0] thresh_c,
`ifdef MMFIFO_IRQ_EN
    output logic                  irq_c,
`endif
    output logic [DATA_WIDTH-1:0] control_c
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wr_ptr, rd_ptr, count, ae_thr, af_thr;
    logic                  ovf, unf;
    logic                  empty, full, almost_empty, almost_full;
    logic                  flush, ext_push, push_ok, pop_req, pop_ok, ovf_set, unf_set;
    logic [DATA_WIDTH-1:0] push_data;
`ifdef MMFIFO_IRQ_EN
    logic [CTRL_IRQ_EN_W-1:0] irq_en;
`endif

    // Occupancy flags and push/pop arbitration; bus push and flush block the stream push
    always_comb begin
        count          = wr_ptr - rd_ptr;
        empty          = (count == '0);
        full           = (count == CW'(DEPTH));
        almost_empty   = (count <= ae_thr) && !empty;
        almost_full    = (count >= af_thr);
        flush          = ctrl_we && wdata[CTRL_FLUSH];
        ext_wr_ready_c = !full && !bus_push && !flush;
        ext_rd_valid_c = !empty;
        ext_push       = ext_wr_en && ext_wr_ready_c;
        push_ok        = (bus_push || ext_push) && !full && !flush;
        push_data      = bus_push ? wdata : ext_wr_data;
        pop_req        = bus_pop || ext_rd_en;
        pop_ok         = pop_req && !empty && !flush;
        ovf_set        = (bus_push || ext_wr_en) && full && !flush;
        unf_set        = pop_req && empty && !flush;
        head_c         = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

    // Register read images
    always_comb begin
        status_c                        = '0;
        status_c[ST_EMPTY]              = empty;
        status_c[ST_FULL]               = full;
        status_c[ST_AEMPTY]             = almost_empty;
        status_c[ST_AFULL]              = almost_full;
        status_c[ST_OVF]                = ovf;
        status_c[ST_UNF]                = unf;
        status_c[ST_COUNT_LSB +: CW]    = count;
        thresh_c                        = '0;
        thresh_c[THR_AE_LSB +: CW]      = ae_thr;
        thresh_c[THR_AF_LSB +: CW]      = af_thr;
        control_c                       = '0;
`ifdef MMFIFO_IRQ_EN
        control_c[CTRL_IRQ_EN_LSB +: CTRL_IRQ_EN_W] = irq_en;
`endif
    end

    // Pointers; flush returns both to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + CW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // Word storage
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
    end

    // Sticky flags (set beats write-1-to-clear) and thresholds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf    <= 1'b0;
            unf    <= 1'b0;
            ae_thr <= CW'(AE_RESET);
            af_thr <= CW'(AF_RESET);
        end else begin
            ovf <= ovf_set || (ovf && !(status_we && wdata[ST_OVF]));
            unf <= unf_set || (unf && !(status_we && wdata[ST_UNF]));
            if (thr_we) begin
                ae_thr <= wdata[THR_AE_LSB +: CW];
                af_thr <= wdata[THR_AF_LSB +: CW];
            end
        end
    end

`ifdef MMFIFO_IRQ_EN
    // Interrupt enables, one per STATUS bit 2..5
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_en <= '0;
        else if (ctrl_we) irq_en <= wdata[CTRL_IRQ_EN_LSB +: CTRL_IRQ_EN_W];
    end

    // Per-channel interrupt request
    always_comb begin
        irq_c = |({unf, ovf, almost_full, almost_empty} & irq_en);
    end
`endif

endmodule

// File: rtl/mm_fifo_multichannel.sv
// NUM_CH FIFOs behind one register port, each with a streaming side port.
// Define MMFIFO_IRQ_EN to build the irq output and per-channel interrupt enables.
module mm_fifo_multichannel
    import mm_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned AE_RESET   = 2,
    parameter int unsigned AF_RESET   = (1 << ADDR_WIDTH) - 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef MMFIFO_IRQ_EN
    output logic irq,
`endif
    mm_fifo_multichannel_if.slave bus
);
    logic [3:0]            ch_sel, off;
    logic                  wr_req, rd_req;
    logic [DATA_WIDTH-1:0] head    [NUM_CH];
    logic [DATA_WIDTH-1:0] status  [NUM_CH];
    logic [DATA_WIDTH-1:0] thresh  [NUM_CH];
    logic [DATA_WIDTH-1:0] control [NUM_CH];
    logic [NUM_CH-1:0]     wr_ready, rd_valid;
    logic [DATA_WIDTH-1:0] rdata_c;
`ifdef MMFIFO_IRQ_EN
    logic [NUM_CH-1:0]     irq_vec;
`endif

    assign ch_sel           = bus.mem_addr[7:4];
    assign off              = bus.mem_addr[3:0];
    assign wr_req           = bus.mem_valid && bus.mem_write;
    assign rd_req           = bus.mem_valid && !bus.mem_write;
    assign bus.ext_wr_ready = wr_ready;
    assign bus.ext_rd_valid = rd_valid;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit = (ch_sel == 4'(c));

        mm_fifo_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .AE_RESET   (AE_RESET),
            .AF_RESET   (AF_RESET)
        ) u_ch (
            .clk            (clk),
            .rst_n          (rst_n),
            .bus_push       (hit && wr_req && (off == OFF_DATA)),
            .bus_pop        (hit && rd_req && (off == OFF_DATA)),
            .status_we      (hit && wr_req && (off == OFF_STATUS)),
            .ctrl_we        (hit && wr_req && (off == OFF_CONTROL)),
            .thr_we         (hit && wr_req && (off == OFF_THRESH)),
            .wdata          (bus.mem_wdata),
            .ext_wr_en      (bus.ext_wr_en[c]),
            .ext_wr_data    (bus.ext_wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .ext_rd_en      (bus.ext_rd_en[c]),
            .ext_wr_ready_c (wr_ready[c]),
            .ext_rd_valid_c (rd_valid[c]),
            .head_c         (head[c]),
            .status_c       (status[c]),
            .thresh_c       (thresh[c]),
`ifdef MMFIFO_IRQ_EN
            .irq_c          (irq_vec[c]),
`endif
            .control_c      (control[c])
        );

        assign bus.ext_rd_data[c*DATA_WIDTH +: DATA_WIDTH] = head[c];
    end

    // Read mux; unmapped channels and offsets read as zero
    always_comb begin
        rdata_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 4'(c)) begin
                case (off)
                    OFF_DATA:    rdata_c = head[c];
                    OFF_STATUS:  rdata_c = status[c];
                    OFF_CONTROL: rdata_c = control[c];
                    OFF_THRESH:  rdata_c = thresh[c];
                    default:     rdata_c = '0;
                endcase
            end
        end
    end

    // Bus response, one cycle after every request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            bus.mem_ready <= bus.mem_valid;
            bus.mem_rdata <= rd_req ? rdata_c : '0;
        end
    end

`ifdef MMFIFO_IRQ_EN
    // Registered interrupt, OR of all channel requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= |irq_vec;
    end
`endif

endmodule

// File: tb/tb_mm_fifo_multichannel.sv
// Bench for mm_fifo_multichannel: directed scenarios plus random traffic
// against a queue-based reference model. Honours MMFIFO_IRQ_EN.
module tb_mm_fifo_multichannel;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mm_fifo_multichannel_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();
`ifdef MMFIFO_IRQ_EN
    logic irq;
`endif

    mm_fifo_multichannel #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NCH),
        .AE_RESET   (2),
        .AF_RESET   (14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef MMFIFO_IRQ_EN
        .irq   (irq),
`endif
        .bus   (bus)
    );

    int n_vec;
    int n_err;

    // Reference model: one queue of words per channel plus register state
    logic [31:0] mq  [NCH][$];
    logic        ovf [NCH];
    logic        unf [NCH];
    logic [4:0]  ae  [NCH];
    logic [4:0]  af  [NCH];
    logic [3:0]  ien [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_word(input int c);
        logic [31:0] s;
        int sz;
        sz      = mq[c].size();
        s       = 32'h0;
        s[0]    = (sz == 0);
        s[1]    = (sz == DEPTH);
        s[2]    = (sz != 0) && (sz <= int'(ae[c]));
        s[3]    = (sz >= int'(af[c]));
        s[4]    = ovf[c];
        s[5]    = unf[c];
        s[12:8] = 5'(sz);
        return s;
    endfunction

    task automatic idle_bus();
        bus.mem_valid   = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = 8'h0;
        bus.mem_wdata   = 32'h0;
        bus.ext_wr_en   = '0;
        bus.ext_rd_en   = '0;
        bus.ext_wr_data = '0;
    endtask

    // One clock: check stream outputs at the negedge, advance the model, check bus response after the edge
    task automatic step();
        logic [31:0] exp_rd, st, wd, head;
        logic        exp_irq, was_rd, was_valid, hit, bpush, bpop, flush, ready;
        int          ch, off, sz;
        @(negedge clk);
        ch        = int'(bus.mem_addr[7:4]);
        off       = int'(bus.mem_addr[3:0]);
        wd        = bus.mem_wdata;
        was_valid = bus.mem_valid;
        was_rd    = bus.mem_valid && !bus.mem_write;
        exp_rd    = 32'h0;
        exp_irq   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            sz    = mq[c].size();
            hit   = bus.mem_valid && (ch == c);
            bpush = hit && bus.mem_write && (off == 0);
            bpop  = hit && !bus.mem_write && (off == 0);
            flush = hit && bus.mem_write && (off == 8) && wd[0];
            head  = (sz > 0) ? mq[c][0] : 32'h0;
            ready = (sz < DEPTH) && !bpush && !flush;
            st    = status_word(c);
            exp_irq = exp_irq | (|(st[5:2] & ien[c]));
            check("ext_wr_ready", 32'(bus.ext_wr_ready[c]), 32'(ready));
            check("ext_rd_valid", 32'(bus.ext_rd_valid[c]), 32'(sz != 0));
            check("ext_rd_data", bus.ext_rd_data[c*DW +: DW], head);
            if (hit && !bus.mem_write) begin
                case (off)
                    0:       exp_rd = head;
                    4:       exp_rd = st;
                    8:       exp_rd = {20'h0, ien[c], 8'h0};
                    12:      exp_rd = {11'h0, af[c], 11'h0, ae[c]};
                    default: exp_rd = 32'h0;
                endcase
            end
            if (hit && bus.mem_write && (off == 4)) begin
                if (wd[4]) ovf[c] = 1'b0;
                if (wd[5]) unf[c] = 1'b0;
            end
            if (hit && bus.mem_write && (off == 12)) begin
                ae[c] = wd[4:0];
                af[c] = wd[20:16];
            end
`ifdef MMFIFO_IRQ_EN
            if (hit && bus.mem_write && (off == 8)) ien[c] = wd[11:8];
`endif
            if (flush) begin
                mq[c].delete();
            end else begin
                if (bpop || bus.ext_rd_en[c]) begin
                    if (sz == 0) unf[c] = 1'b1;
                    else void'(mq[c].pop_front());
                end
                if (bpush || bus.ext_wr_en[c]) begin
                    if (sz == DEPTH) ovf[c] = 1'b1;
                    else mq[c].push_back(bpush ? wd : bus.ext_wr_data[c*DW +: DW]);
                end
            end
        end
        @(posedge clk);
        #1;
        check("mem_ready", 32'(bus.mem_ready), 32'(was_valid));
        if (was_rd) check("mem_rdata", bus.mem_rdata, exp_rd);
`ifdef MMFIFO_IRQ_EN
        check("irq", 32'(irq), 32'(exp_irq));
`endif
    endtask

    task automatic bus_wr(input int ch, input int off, input logic [31:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = {4'(ch), 4'(off)};
        bus.mem_wdata = d;
        step();
        idle_bus();
    endtask

    task automatic bus_rd(input int ch, input int off, output logic [31:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_write = 1'b0;
        bus.mem_addr  = {4'(ch), 4'(off)};
        step();
        d = bus.mem_rdata;
        idle_bus();
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  offs [5];
        n_vec = 0;
        n_err = 0;
        offs  = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h6};
        idle_bus();
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            ovf[c] = 1'b0;
            unf[c] = 1'b0;
            ae[c]  = 5'd2;
            af[c]  = 5'd14;
            ien[c] = 4'h0;
        end

        // Outputs while reset is held
        repeat (2) @(negedge clk);
        check("rst_mem_ready", 32'(bus.mem_ready), 32'h0);
        check("rst_mem_rdata", bus.mem_rdata, 32'h0);
        check("rst_wr_ready", 32'(bus.ext_wr_ready), 32'hF);
        check("rst_rd_valid", 32'(bus.ext_rd_valid), 32'h0);
`ifdef MMFIFO_IRQ_EN
        check("rst_irq", 32'(irq), 32'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset register values
        bus_rd(0, 4, rd);  check("p1_status", rd, 32'h0000_0001);
        bus_rd(0, 12, rd); check("p1_thresh", rd, 32'h000E_0002);

        // Fill ch1 through DATA, then overflow and clear
        for (int i = 0; i < 16; i++) bus_wr(1, 0, 32'h100 + 32'(i));
        bus_wr(1, 0, 32'h999);
        bus_rd(1, 4, rd);  check("p2_full_ovf", rd, 32'h0000_101A);
        bus_rd(0, 4, rd);  check("p2_ch0_idle", rd, 32'h0000_0001);
        bus_wr(1, 4, 32'h10);
        bus_rd(1, 4, rd);  check("p2_w1c", rd, 32'h0000_100A);

        // Bus push and stream push collide on ch2
        bus.mem_valid = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = 8'h20;
        bus.mem_wdata = 32'h222;
        bus.ext_wr_en = 4'b0100;
        bus.ext_wr_data[2*DW +: DW] = 32'h333;
        #1;
        check("p3_wr_ready", 32'(bus.ext_wr_ready[2]), 32'h0);
        step();
        idle_bus();
        bus_rd(2, 4, rd);  check("p3_status", rd, 32'h0000_0104);
        bus_rd(2, 0, rd);  check("p3_word", rd, 32'h0000_0222);

        // Underflow on empty ch3, then a stream push
        bus_rd(3, 0, rd);  check("p4_pop_empty", rd, 32'h0);
        bus_rd(3, 4, rd);  check("p4_unf", rd, 32'h0000_0021);
        bus.ext_wr_en = 4'b1000;
        bus.ext_wr_data[3*DW +: DW] = 32'hA5;
        step();
        idle_bus();
        check("p4_rd_valid", 32'(bus.ext_rd_valid[3]), 32'h1);
        check("p4_rd_data", bus.ext_rd_data[3*DW +: DW], 32'hA5);

        // Thresholds and flush on ch0 (with a sticky underflow to keep)
        bus_wr(0, 12, 32'h0006_0004);
        bus_rd(0, 0, rd);
        for (int i = 0; i < 6; i++) bus_wr(0, 0, 32'h50 + 32'(i));
        bus_rd(0, 4, rd);  check("p5_thresh", rd, 32'h0000_0628);
        bus_wr(0, 8, 32'h1);
        bus_rd(0, 4, rd);  check("p5_flush", rd, 32'h0000_0021);

`ifdef MMFIFO_IRQ_EN
        // Overflow interrupt on ch1
        bus_wr(1, 8, 32'h400);
        bus_rd(1, 8, rd);  check("p6_irq_en", rd, 32'h0000_0400);
        bus_wr(1, 0, 32'hBAD);
        step();
        check("p6_irq_set", 32'(irq), 32'h1);
        bus_wr(1, 4, 32'h10);
        step();
        check("p6_irq_clr", 32'(irq), 32'h0);
`else
        bus_wr(1, 8, 32'hF00);
        bus_rd(1, 8, rd);  check("p6_no_irq_en", rd, 32'h0);
`endif

        // Random traffic, alternating fill-heavy and drain-heavy phases
        for (int n = 0; n < 3000; n++) begin
            int          pw, pr;
            logic [31:0] wd;
            logic [3:0]  o;
            pw = (((n / 250) % 2) == 0) ? 70 : 25;
            pr = 95 - pw;
            o  = offs[$urandom_range(0, 4)];
            wd = $urandom;
            if ((o == 4'h8) && ($urandom_range(0, 7) != 0)) wd[0] = 1'b0;
            bus.mem_valid = ($urandom_range(0, 2) == 0);
            bus.mem_write = 1'($urandom_range(0, 1));
            bus.mem_addr  = {4'($urandom_range(0, 5)), o};
            bus.mem_wdata = wd;
            for (int c = 0; c < NCH; c++) begin
                bus.ext_wr_en[c] = (int'($urandom_range(0, 99)) < pw);
                bus.ext_rd_en[c] = (int'($urandom_range(0, 99)) < pr);
                bus.ext_wr_data[c*DW +: DW] = $urandom;
            end
            step();
        end
        idle_bus();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mm_fifo_multichannel.md
Name: mm_fifo_multichannel

Overview:
Multi-channel successor to the single memory-mapped FIFO.
- NUM_CH independent FIFOs share one memory-mapped register port. Each FIFO has a streaming push/pop side port.
- Adds programmable thresholds, sticky overflow/underflow flags, an external write-ready handshake, and an optional interrupt.
- Sits between a CPU bus bridge and streaming datapath blocks.

Parameters:
DATA_WIDTH, 32, word width; must be >= 32.
ADDR_WIDTH, 4, per-channel depth = 2^ADDR_WIDTH; range 1..7.
NUM_CH, 4, channel count; range 1..16.
AE_RESET, 2, reset value of each channel's almost-empty threshold.
AF_RESET, 2^ADDR_WIDTH-2, reset value of each channel's almost-full threshold.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
mem_valid  in  1  bus request.
mem_write  in  1  1 = write, 0 = read.
mem_addr  in  8  [7:4] = channel, [3:0] = register offset.
mem_wdata  in  DATA_WIDTH  write data.
mem_ready  out  1  response strobe, one cycle after the request.
mem_rdata  out  DATA_WIDTH  registered read data.
ext_wr_en  in  NUM_CH  per-channel push request.
ext_wr_data  in  NUM_CH*DATA_WIDTH  push data; channel c is at [c*DATA_WIDTH +: DATA_WIDTH].
ext_wr_ready  out  NUM_CH  push accepted when en && ready.
ext_rd_en  in  NUM_CH  per-channel pop.
ext_rd_data  out  NUM_CH*DATA_WIDTH  head word (first-word-fall-through); 0 when empty.
ext_rd_valid  out  NUM_CH  channel not empty.
irq  out  1  level interrupt; present only with MMFIFO_IRQ_EN.

Behaviour:
Clocking and reset:
- One clock domain.
- rst_n low asynchronously clears all pointers, sticky flags and IRQ enables, and loads thresholds with AE_RESET/AF_RESET.
- Outputs during reset: mem_ready=0, mem_rdata=0, ext_wr_ready=all 1s, ext_rd_valid=0, irq=0.

Register map (per channel):
- 0x0 DATA. Write pushes mem_wdata. Read pops; mem_rdata = head word, or 0 if empty.
- 0x4 STATUS, read-only, except write-1-to-clear of bits [5:4].
  - bit0 empty, bit1 full, bit2 almost_empty, bit3 almost_full.
  - bit4 overflow (sticky), bit5 underflow (sticky).
  - [8+ADDR_WIDTH:8] count.
- 0x8 CONTROL, write-only, self-clearing.
  - bit0 flush.
  - bits[11:8] irq_en, one per status bit 2..5, retained; reads return irq_en at [11:8].
- 0xC THRESH, read/write.
  - [ADDR_WIDTH:0] ae_thr.
  - [16+ADDR_WIDTH:16] af_thr.

Access handshake:
- mem_ready <= mem_valid, every cycle. The bus must not issue back-to-back requests that depend on each other's result.
- Unmapped offsets and channel >= NUM_CH: reads return 0, writes are ignored, mem_ready still responds.

Status flags:
- count = wr_ptr - rd_ptr, in ADDR_WIDTH+1 bits; pointers wrap naturally.
- empty: count==0. full: count==2^ADDR_WIDTH.
- almost_empty: count<=ae_thr && !empty.
- almost_full: count>=af_thr.

Push rules:
- A push is accepted only if the channel is not full. A simultaneous pop does not permit a push while full.
- A push to a full channel is dropped and sets overflow. This covers both a memory-mapped push and ext_wr_en while ext_wr_ready=0.

Pop rules:
- A pop is accepted only if the channel is not empty. A simultaneous push does not permit a pop while empty.
- A pop from an empty channel sets underflow and has no other effect.

Simultaneous events, same channel, same cycle:
- A memory-mapped DATA write blocks the ext push: ext_wr_ready=0 that cycle and the ext push is not accepted. The same applies to a flush. ext_wr_ready = !full && !(bus push or flush to that channel).
- If the bus and ext_rd_en both pop, exactly one word is removed. mem_rdata and ext_rd_data both carry that word; underflow is not set.
- Push + pop, both legal: count is unchanged.
- Flush overrides push and pop. Pointers go to 0 and sticky flags are kept.
- A W1C on a sticky flag in the same cycle that sets it: the set wins.

Optional Feature:
Macro MMFIFO_IRQ_EN.
- Defined: irq is a registered output (1-cycle delay) equal to the OR over channels of (status[5:2] & irq_en).
- Not defined: the irq port and irq_en storage are absent. CONTROL[11:8] writes are ignored and read as 0.

Decomposition:
- Package mm_fifo_pkg holds:
  - register offsets 0x0/0x4/0x8/0xC;
  - STATUS bit indices and the count LSB (8);
  - CONTROL bit indices;
  - THRESH field LSBs (0, 16).
- Sub-module mm_fifo_channel holds one channel's storage, pointers, thresholds, sticky flags and ready/valid logic. The top generates NUM_CH instances and does address decode, arbitration and read muxing.

Test Plan:
1. Reset, then read ch0 STATUS -> 0x00000001. Read THRESH -> 0x000E0002 (defaults).
2. Push 16 words (0x100..0x10F) to ch1 via DATA, then a 17th -> STATUS[1]=1, [4]=1, count=16; ch0 unaffected. W1C 0x10 -> bit4 clears.
3. ext push on ch2 and bus push to ch2 in the same cycle -> ext_wr_ready[2]=0 that cycle; only the bus word is stored, count=1.
4. Pop from empty ch3 via the bus -> mem_rdata=0 and underflow=1. Then ext push 0xA5 -> ext_rd_valid[3]=1 and ext_rd_data=0xA5.
5. Set THRESH ch0 ae=4, af=6; push 6 words -> almost_full=1, almost_empty=0. Flush -> count=0 and sticky flags retained.
6. With MMFIFO_IRQ_EN, set ch1 irq_en bit for overflow and overflow ch1 -> irq=1 one cycle later. W1C the flag -> irq=0.
